// File: rtl/opl_sched_pkg.sv
// Shared types and constants for the OPL2 write scheduler: FSM state
// encoding, the silence-sweep table layout and the register/value pair type.
package opl_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_PULSE,
    A_WAIT,
    D_PULSE,
    D_WAIT
  } state_t;

  // Key-off block: one write per channel to the 0xB0..0xB8 registers.
  localparam logic [7:0] KEYOFF_BASE = 8'hB0;
  localparam logic [4:0] KEYOFF_N    = 5'd9;

  // Total-level block: one write per operator slot, maximum attenuation.
  localparam logic [7:0] TL_BASE = 8'h40;
  localparam logic [4:0] TL_N    = 5'd22;
  localparam logic [7:0] TL_MAX  = 8'h3F;

  localparam logic [4:0] SWEEP_LEN  = 5'd31;
  localparam logic [4:0] SWEEP_LAST = SWEEP_LEN - 5'd1;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } opl_pair_t;

endpackage

// File: rtl/opl_write_scheduler_rom.sv
// Silence-sweep table: maps a sweep index to the register/value pair that
// keys off a channel (first block) or fully attenuates an operator (second
// block). Indices past the end of the table return an all-zero pair.
module opl_silence_rom
  import opl_sched_pkg::*;
(
  input  logic [4:0] idx_i,
  output opl_pair_t  pair_o
);

  // Table lookup by plain offset arithmetic on the index.
  always_comb begin
    pair_o = '0;
    if (idx_i < KEYOFF_N) begin
      pair_o.addr = KEYOFF_BASE + {3'b000, idx_i};
      pair_o.data = 8'h00;
    end else if (idx_i < (KEYOFF_N + TL_N)) begin
      pair_o.addr = TL_BASE + {3'b000, idx_i - KEYOFF_N};
      pair_o.data = TL_MAX;
    end
  end

endmodule

// File: rtl/opl_write_scheduler.sv
// Sequences every write to the jtopl2 host bus (address pulse, settle,
// data pulse, settle) and arbitrates between the host pair FIFO and the
// internal silence sweep. The sweep always wins at IDLE; a write in flight
// is never shortened or interrupted except by rst.
module opl_write_scheduler
  import opl_sched_pkg::*;
#(
  parameter int WR_PULSE  = 2,
  parameter int ADDR_WAIT = 28,
  parameter int DATA_WAIT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_valid,
  input  logic [7:0] host_reg,
  input  logic [7:0] host_val,
  output logic       host_ready,
  input  logic       silence_req,
  input  logic       abort,
  output logic       busy,
  output logic       silence_active,
  output logic       opl_wr_n,
  output logic       opl_a0,
  output logic [7:0] opl_din
);

  localparam int MAX_PERIOD =
    (WR_PULSE > ADDR_WAIT) ? ((WR_PULSE > DATA_WAIT) ? WR_PULSE : DATA_WAIT)
                           : ((ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT);
  localparam int CNT_W = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;

  // The counter is loaded with length-1 on state entry and the phase ends
  // on the cycle it reads zero, so a phase of N cycles needs N-1 to fit.
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_AWAIT = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_DWAIT = CNT_W'(DATA_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pending_q;
  logic [4:0]       idx_q;
  logic             adv_q;       // completing write should advance idx_q
  logic             sweep_wr_q;  // write in flight belongs to the sweep
  logic             wr_n_q;
  logic             a0_q;
  logic [7:0]       din_q;
  logic [7:0]       val_q;

  opl_pair_t        rom_pair;
  logic             take_sweep;
  logic             take_host;
  logic             cnt_done;
  logic [7:0]       launch_reg_d;
  logic [7:0]       launch_val_d;

  opl_silence_rom u_rom (
    .idx_i  (idx_q),
    .pair_o (rom_pair)
  );

  assign host_ready     = (state_q == IDLE) & ~pending_q & ~rst;
  assign take_sweep     = (state_q == IDLE) & pending_q;
  assign take_host      = host_valid & host_ready;
  assign launch_reg_d   = take_sweep ? rom_pair.addr : host_reg;
  assign launch_val_d   = take_sweep ? rom_pair.data : host_val;
  assign cnt_done       = (cnt_q == '0);

  assign busy           = (state_q != IDLE);
  assign silence_active = pending_q | sweep_wr_q;
  assign opl_wr_n       = wr_n_q;
  assign opl_a0         = a0_q;
  assign opl_din        = din_q;

  // Write-sequencing FSM with registered bus outputs and sweep bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      idx_q      <= 5'd0;
      adv_q      <= 1'b0;
      sweep_wr_q <= 1'b0;
      wr_n_q     <= 1'b1;
      a0_q       <= 1'b0;
      din_q      <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_sweep || take_host) begin
            state_q    <= A_PULSE;
            cnt_q      <= LD_PULSE;
            wr_n_q     <= 1'b0;
            a0_q       <= 1'b0;
            din_q      <= launch_reg_d;
            adv_q      <= take_sweep;
            sweep_wr_q <= take_sweep;
          end
        end
        A_PULSE: begin
          if (cnt_done) begin
            state_q <= A_WAIT;
            cnt_q   <= LD_AWAIT;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        A_WAIT: begin
          if (cnt_done) begin
            state_q <= D_PULSE;
            cnt_q   <= LD_PULSE;
            wr_n_q  <= 1'b0;
            a0_q    <= 1'b1;
            din_q   <= val_q;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        D_PULSE: begin
          if (cnt_done) begin
            state_q <= D_WAIT;
            cnt_q   <= LD_DWAIT;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        D_WAIT: begin
          if (cnt_done) begin
            state_q    <= IDLE;
            adv_q      <= 1'b0;
            sweep_wr_q <= 1'b0;
            if (adv_q) begin
              if (idx_q == SWEEP_LAST) begin
                pending_q <= 1'b0;
                idx_q     <= 5'd0;
              end else begin
                idx_q <= idx_q + 5'd1;
              end
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          wr_n_q  <= 1'b1;
        end
      endcase

      // Abort drops the rest of the sweep; the entry in flight still runs
      // to completion but no longer advances the index.
      if (abort) begin
        pending_q <= 1'b0;
        idx_q     <= 5'd0;
        adv_q     <= 1'b0;
      end
      // A (re)start request overrides abort and any pending advance so the
      // next sweep write is always entry 0.
      if (silence_req) begin
        pending_q <= 1'b1;
        idx_q     <= 5'd0;
        adv_q     <= 1'b0;
      end
    end
  end

  // Holds the value byte of the pair being written until its data phase.
  always_ff @(posedge clk) begin
    if (take_sweep || take_host) begin
      val_q <= launch_val_d;
    end
  end

endmodule

// File: tb/tb_opl_write_scheduler.sv
// Self-checking bench for opl_write_scheduler: a bus monitor reconstructs
// every completed OPL write, and each scenario compares the reconstructed
// write list and timing against a reference list built from the sweep table
// rules and the host pairs that were queued.
module tb_opl_write_scheduler;

  localparam int WRITE_CYC = 233;   // 2*2 + 28 + 200 + 1
  localparam int DATA_OFS  = 30;    // address pulse start -> data pulse start

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_valid = 1'b0;
  logic [7:0] host_reg = 8'h00;
  logic [7:0] host_val = 8'h00;
  logic       silence_req = 1'b0;
  logic       abort = 1'b0;
  logic       host_ready;
  logic       busy;
  logic       silence_active;
  logic       opl_wr_n;
  logic       opl_a0;
  logic [7:0] opl_din;

  opl_write_scheduler #(
    .WR_PULSE  (2),
    .ADDR_WAIT (28),
    .DATA_WAIT (200)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .host_valid     (host_valid),
    .host_reg       (host_reg),
    .host_val       (host_val),
    .host_ready     (host_ready),
    .silence_req    (silence_req),
    .abort          (abort),
    .busy           (busy),
    .silence_active (silence_active),
    .opl_wr_n       (opl_wr_n),
    .opl_a0         (opl_a0),
    .opl_din        (opl_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] v;
  } pair_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] v;
    int         ta;
    int         td;
  } wr_t;

  pair_t fifo[$];
  wr_t   cap[$];
  int    hs_q[$];
  pair_t exp_q[$];

  int cyc = 0;
  int addr_cnt = 0;
  int glitch = 0;
  int bad_pulse = 0;
  int bad_gap = 0;
  int n_vec = 0;
  int n_bad = 0;

  logic s_ready, s_busy, s_act;
  int   s_cyc;

  // monitor state
  logic       m_prev;
  int         m_len;
  logic       m_a0;
  logic [7:0] m_din;
  logic       m_have;
  logic [7:0] m_reg;
  int         m_ta;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Bus monitor: rebuilds each write from the wr_n pulses it observes.
  initial begin
    wr_t w;
    m_prev = 1'b1; m_len = 0; m_have = 1'b0; m_a0 = 1'b0; m_din = 8'h00;
    m_reg = 8'h00; m_ta = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_prev = 1'b1; m_have = 1'b0; m_len = 0;
      end else begin
        if (!opl_wr_n) begin
          if (m_prev) begin
            m_len = 1; m_a0 = opl_a0; m_din = opl_din;
            if (!opl_a0) begin
              m_reg = opl_din; m_ta = cyc; m_have = 1'b1;
              addr_cnt = addr_cnt + 1;
            end else if (m_have) begin
              if (cyc - m_ta != DATA_OFS) bad_gap = bad_gap + 1;
              w.r = m_reg; w.v = opl_din; w.ta = m_ta; w.td = cyc;
              cap.push_back(w);
              m_have = 1'b0;
            end
          end else begin
            m_len = m_len + 1;
            if (opl_a0 !== m_a0 || opl_din !== m_din) glitch = glitch + 1;
          end
        end else if (!m_prev) begin
          if (m_len != 2) bad_pulse = bad_pulse + 1;
        end
        m_prev = opl_wr_n;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic pair_t sweep_entry(int i);
    pair_t p;
    if (i < 9) begin
      p.r = 8'(8'hB0 + i);
      p.v = 8'h00;
    end else begin
      p.r = 8'(8'h40 + (i - 9));
      p.v = 8'h3F;
    end
    return p;
  endfunction

  function automatic pair_t rand_pair();
    pair_t p;
    p.r = 8'($urandom_range(0, 255));
    p.v = 8'($urandom_range(0, 255));
    return p;
  endfunction

  task automatic drive_host();
    host_valid = (fifo.size() > 0);
    if (fifo.size() > 0) begin
      host_reg = fifo[0].r;
      host_val = fifo[0].v;
    end else begin
      host_reg = 8'h00;
      host_val = 8'h00;
    end
  endtask

  // One clock: sample at the falling edge, apply the rising edge, then update
  // inputs; silence_req/abort are therefore single-cycle pulses.
  task automatic step();
    logic hs;
    @(negedge clk);
    s_ready = host_ready; s_busy = busy; s_act = silence_active; s_cyc = cyc;
    hs = host_valid && host_ready;
    if (hs) hs_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    if (hs) void'(fifo.pop_front());
    silence_req = 1'b0;
    abort = 1'b0;
    drive_host();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_hs(int n, int budget);
    int b = budget;
    while (hs_q.size() < n && b > 0) begin step(); b--; end
    if (hs_q.size() < n) begin
      n_vec++; n_bad++;
      $display("FAIL hs_timeout: got %0d handshakes, want %0d", hs_q.size(), n);
    end
  endtask

  task automatic wait_cap(int n, int budget);
    int b = budget;
    while (cap.size() < n && b > 0) begin step(); b--; end
    if (cap.size() < n) begin
      n_vec++; n_bad++;
      $display("FAIL write_timeout: got %0d writes, want %0d", cap.size(), n);
    end
  endtask

  task automatic wait_addr(int n, int budget);
    int b = budget;
    while (addr_cnt < n && b > 0) begin step(); b--; end
    if (addr_cnt < n) begin
      n_vec++; n_bad++;
      $display("FAIL addr_timeout: got %0d address phases, want %0d", addr_cnt, n);
    end
  endtask

  task automatic wait_quiet(int budget);
    int b = budget;
    step();
    while ((s_act || s_busy) && b > 0) begin step(); b--; end
    if (s_act || s_busy) begin
      n_vec++; n_bad++;
      $display("FAIL quiet_timeout: got busy=%0b active=%0b, want 0/0", s_busy, s_act);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run(3);
    n_vec++; if (opl_wr_n !== 1'b1) begin n_bad++; $display("FAIL rst_wr_n: got %b want 1", opl_wr_n); end
    n_vec++; if (opl_a0 !== 1'b0) begin n_bad++; $display("FAIL rst_a0: got %b want 0", opl_a0); end
    n_vec++; if (opl_din !== 8'h00) begin n_bad++; $display("FAIL rst_din: got %h want 00", opl_din); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (silence_active !== 1'b0) begin n_bad++; $display("FAIL rst_active: got %b want 0", silence_active); end
    n_vec++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_in_reset: got %b want 0", host_ready); end
    rst = 1'b0;
    #1;
    n_vec++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", host_ready); end
  endtask

  task automatic test_single_write();
    pair_t p;
    int t, b;
    cap.delete(); hs_q.delete();
    p.r = 8'h20; p.v = 8'h01;
    fifo.push_back(p); drive_host();
    wait_hs(1, 10);
    wait_cap(1, 100);
    if (hs_q.size() >= 1 && cap.size() >= 1) begin
      t = hs_q[0];
      n_vec++; if (cap[0].r !== 8'h20) begin n_bad++; $display("FAIL single_reg: got %h want 20", cap[0].r); end
      n_vec++; if (cap[0].v !== 8'h01) begin n_bad++; $display("FAIL single_val: got %h want 01", cap[0].v); end
      n_vec++; if (cap[0].ta !== t) begin n_bad++; $display("FAIL single_addr_time: got %0d want %0d", cap[0].ta, t); end
      n_vec++; if (cap[0].td !== t + DATA_OFS) begin n_bad++; $display("FAIL single_data_time: got %0d want %0d", cap[0].td, t + DATA_OFS); end
      b = 400;
      step();
      while (!s_ready && b > 0) begin step(); b--; end
      n_vec++;
      if (s_cyc !== t + WRITE_CYC - 1 || !s_ready) begin
        n_bad++; $display("FAIL single_ready_time: got cycle %0d want %0d", s_cyc, t + WRITE_CYC - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    pair_t p;
    cap.delete(); hs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      p = rand_pair(); fifo.push_back(p); exp_q.push_back(p);
    end
    drive_host();
    wait_cap(3, 3 * WRITE_CYC + 50);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (i >= cap.size()) begin
        n_bad++; $display("FAIL b2b_pair%0d: got missing want %h/%h", i, exp_q[i].r, exp_q[i].v);
      end else if (cap[i].r !== exp_q[i].r || cap[i].v !== exp_q[i].v) begin
        n_bad++; $display("FAIL b2b_pair%0d: got %h/%h want %h/%h", i, cap[i].r, cap[i].v, exp_q[i].r, exp_q[i].v);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_vec++;
      if (i >= hs_q.size()) begin
        n_bad++; $display("FAIL b2b_interval%0d: got missing want %0d", i, WRITE_CYC);
      end else if (hs_q[i] - hs_q[i-1] != WRITE_CYC) begin
        n_bad++; $display("FAIL b2b_interval%0d: got %0d want %0d", i, hs_q[i] - hs_q[i-1], WRITE_CYC);
      end
    end
    wait_quiet(300);
  endtask

  task automatic test_sweep();
    int act_cnt = 0, viol = 0, gaps = 0;
    bit started = 0;
    cap.delete(); hs_q.delete();
    silence_req = 1'b1;
    for (int k = 0; k < 8000; k++) begin
      step();
      if (s_act) begin
        act_cnt++; started = 1;
        if (s_ready) viol++;
      end else if (started) begin
        break;
      end
    end
    n_vec++; if (act_cnt != 31 * WRITE_CYC) begin n_bad++; $display("FAIL sweep_active_len: got %0d want %0d", act_cnt, 31 * WRITE_CYC); end
    n_vec++; if (viol != 0) begin n_bad++; $display("FAIL sweep_ready_low: got %0d ready cycles want 0", viol); end
    n_vec++; if (cap.size() != 31) begin n_bad++; $display("FAIL sweep_count: got %0d want 31", cap.size()); end
    for (int i = 0; i < 31 && i < cap.size(); i++) begin
      pair_t e = sweep_entry(i);
      n_vec++;
      if (cap[i].r !== e.r || cap[i].v !== e.v) begin
        n_bad++; $display("FAIL sweep_entry%0d: got %h/%h want %h/%h", i, cap[i].r, cap[i].v, e.r, e.v);
      end
      if (i > 0 && cap[i].ta - cap[i-1].ta != WRITE_CYC) gaps++;
    end
    n_vec++; if (gaps != 0) begin n_bad++; $display("FAIL sweep_spacing: got %0d bad gaps want 0", gaps); end
  endtask

  task automatic test_preemption();
    pair_t a, bp, e;
    int d;
    cap.delete(); hs_q.delete(); exp_q.delete();
    a = rand_pair(); bp = rand_pair();
    exp_q.push_back(a);
    for (int i = 0; i < 31; i++) exp_q.push_back(sweep_entry(i));
    exp_q.push_back(bp);
    fifo.push_back(a); drive_host();
    wait_hs(1, 10);
    d = $urandom_range(32, 200);
    run(d);
    fifo.push_back(bp); drive_host();
    silence_req = 1'b1;
    step();
    wait_cap(33, 34 * WRITE_CYC);
    n_vec++; if (cap.size() != 33) begin n_bad++; $display("FAIL preempt_count: got %0d want 33", cap.size()); end
    for (int i = 0; i < 33 && i < cap.size(); i++) begin
      e = exp_q[i];
      n_vec++;
      if (cap[i].r !== e.r || cap[i].v !== e.v) begin
        n_bad++; $display("FAIL preempt_write%0d: got %h/%h want %h/%h", i, cap[i].r, cap[i].v, e.r, e.v);
      end
    end
    if (cap.size() >= 33 && hs_q.size() >= 2) begin
      n_vec++; if (cap[1].ta - cap[0].ta != WRITE_CYC) begin n_bad++; $display("FAIL preempt_sweep_start: got gap %0d want %0d", cap[1].ta - cap[0].ta, WRITE_CYC); end
      n_vec++; if (hs_q[1] != cap[31].ta + WRITE_CYC) begin n_bad++; $display("FAIL preempt_host_held: got hs %0d want %0d", hs_q[1], cap[31].ta + WRITE_CYC); end
    end
    wait_quiet(300);
  endtask

  task automatic test_same_cycle();
    pair_t c, e;
    cap.delete(); hs_q.delete();
    c = rand_pair();
    fifo.push_back(c); drive_host();
    silence_req = 1'b1;
    step();
    n_vec++; if (hs_q.size() != 1) begin n_bad++; $display("FAIL same_hs: got %0d handshakes want 1", hs_q.size()); end
    wait_cap(32, 33 * WRITE_CYC);
    for (int i = 0; i < 32 && i < cap.size(); i++) begin
      e = (i == 0) ? c : sweep_entry(i - 1);
      n_vec++;
      if (cap[i].r !== e.r || cap[i].v !== e.v) begin
        n_bad++; $display("FAIL same_write%0d: got %h/%h want %h/%h", i, cap[i].r, cap[i].v, e.r, e.v);
      end
    end
    wait_quiet(300);
  endtask

  task automatic test_abort_restart();
    int base;
    pair_t e;
    cap.delete();
    base = addr_cnt;
    silence_req = 1'b1;
    step();
    wait_addr(base + 6, 7 * WRITE_CYC);
    run($urandom_range(1, 200));
    abort = 1'b1;
    step();
    wait_quiet(WRITE_CYC);
    run(300);
    n_vec++; if (cap.size() != 6) begin n_bad++; $display("FAIL abort_count: got %0d want 6", cap.size()); end
    if (cap.size() >= 6) begin
      e = sweep_entry(5);
      n_vec++; if (cap[5].r !== e.r || cap[5].v !== e.v) begin n_bad++; $display("FAIL abort_last: got %h/%h want %h/%h", cap[5].r, cap[5].v, e.r, e.v); end
    end
    n_vec++; if (silence_active !== 1'b0) begin n_bad++; $display("FAIL abort_active: got %b want 0", silence_active); end

    // abort with nothing to abort
    abort = 1'b1;
    step();
    n_vec++; if (host_ready !== 1'b1 || busy !== 1'b0 || silence_active !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got ready/busy/active %b%b%b want 100", host_ready, busy, silence_active);
    end

    // abort and silence_req together start a sweep; restart during entry 12
    cap.delete();
    base = addr_cnt;
    abort = 1'b1; silence_req = 1'b1;
    step();
    wait_addr(base + 13, 14 * WRITE_CYC);
    run($urandom_range(1, 200));
    silence_req = 1'b1;
    step();
    wait_cap(44, 33 * WRITE_CYC);
    n_vec++; if (cap.size() != 44) begin n_bad++; $display("FAIL restart_count: got %0d want 44", cap.size()); end
    for (int i = 0; i < 44 && i < cap.size(); i++) begin
      e = (i < 13) ? sweep_entry(i) : sweep_entry(i - 13);
      n_vec++;
      if (cap[i].r !== e.r || cap[i].v !== e.v) begin
        n_bad++; $display("FAIL restart_write%0d: got %h/%h want %h/%h", i, cap[i].r, cap[i].v, e.r, e.v);
      end
    end
    wait_quiet(300);
  endtask

  task automatic test_reset_mid();
    pair_t p;
    cap.delete(); hs_q.delete();
    p = rand_pair();
    fifo.push_back(p); drive_host();
    wait_hs(1, 10);
    run($urandom_range(2, 27));
    rst = 1'b1;
    step();
    n_vec++; if (opl_wr_n !== 1'b1) begin n_bad++; $display("FAIL midrst_wr_n: got %b want 1", opl_wr_n); end
    n_vec++; if (opl_a0 !== 1'b0) begin n_bad++; $display("FAIL midrst_a0: got %b want 0", opl_a0); end
    n_vec++; if (opl_din !== 8'h00) begin n_bad++; $display("FAIL midrst_din: got %h want 00", opl_din); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rst = 1'b0;
    #1;
    n_vec++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", host_ready); end
    run(300);
    n_vec++; if (cap.size() != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst_no_replay: got %0d writes busy=%b want 0 writes busy=0", cap.size(), busy);
    end
  endtask

  task automatic test_bus_integrity();
    n_vec++; if (glitch != 0) begin n_bad++; $display("FAIL bus_stable: got %0d changes during wr_n low want 0", glitch); end
    n_vec++; if (bad_pulse != 0) begin n_bad++; $display("FAIL pulse_width: got %0d bad pulses want 0", bad_pulse); end
    n_vec++; if (bad_gap != 0) begin n_bad++; $display("FAIL addr_to_data: got %0d bad gaps want 0", bad_gap); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_sweep();
    test_preemption();
    test_same_cycle();
    test_abort_restart();
    test_reset_mid();
    test_bus_integrity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
